// File: rtl/rom_arb_defs.sv
// rtl/rom_arb_defs.sv - shared state encodings and default widths for the ROM arbiter
package rom_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 4;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner select starting at ptr
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     win_oh,
  output logic [PTR_W-1:0] win_idx,
  output logic             win_any
);

  int          c;
  logic [N-1:0] req_sh;

  // Scan from the far end so the candidate closest to ptr is assigned last and wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    c       = 0;
    req_sh  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c      = (int'(ptr) + k) % N;
      req_sh = req >> c;
      if (req_sh[0]) begin
        win_oh  = N'(1) << c;
        win_idx = PTR_W'(c);
        win_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - round-robin arbiter and read sequencer sharing one synchronous ROM
module rom_arbiter
  import rom_arb_defs::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic                      rom_en,
  input  logic [DATA_W-1:0]         rom_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 3;

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    ptr, owner, win_idx;
  logic [NUM_REQ-1:0]  win_oh;
  logic                win_any;
  logic [ADDR_W-1:0]   addr_q, win_addr;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   data_q;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  assign win_addr = ADDR_W'(req_addr >> (int'(win_idx) * ADDR_W));
  assign rom_addr = addr_q;
  assign rsp_data = data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    rsp_valid = '0;
    rom_en    = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (win_any) begin
          gnt       = win_oh;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rom_en    = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        rom_en = 1'b1;
        if (cnt == '0) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = NUM_REQ'(1) << owner;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Owner, address and pointer only move on a grant; addr_q doubles as the held rom_addr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr    <= '0;
      owner  <= '0;
      addr_q <= '0;
      cnt    <= '0;
      data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_any) begin
            owner  <= win_idx;
            addr_q <= win_addr;
            ptr    <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
          end
        end
        ST_ISSUE: cnt <= CNT_W'(ROM_LAT - 1);
        ST_WAIT: begin
          if (cnt == '0) data_q <= rom_data;
          else           cnt    <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - self-checking bench for rom_arbiter
module tb_rom_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req, gnt, rsp_valid, rsp_data, rom_data;
  logic [7:0] req_addr;
  logic [1:0] rom_addr;
  logic       busy, rom_en;

  logic [3:0] req3, gnt3, rsp_valid3, rsp_data3, rom_data3;
  logic [7:0] req_addr3;
  logic [1:0] rom_addr3;
  logic       busy3, rom_en3;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [3:0] req;
    logic [7:0] addr;
    logic [3:0] exp_gnt;
    int         gap;
  } vec_t;
  vec_t vecs[9];

  rom_arbiter #(.NUM_REQ(4), .ADDR_W(2), .DATA_W(4), .ROM_LAT(1)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data)
  );

  rom_arbiter #(.NUM_REQ(4), .ADDR_W(2), .DATA_W(4), .ROM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .req_addr(req_addr3), .gnt(gnt3),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .busy(busy3),
    .rom_addr(rom_addr3), .rom_en(rom_en3), .rom_data(rom_data3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ROM: data(addr) = {addr, ~addr}, one-cycle registered read.
  always @(posedge clk) begin
    if (rom_en)  rom_data  <= {rom_addr, ~rom_addr};
    if (rom_en3) rom_data3 <= {rom_addr3, ~rom_addr3};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("idle_timeout", busy, 0);
  endtask

  // Scoreboard: push {owner, expected data} on each grant, pop on each response.
  always @(negedge clk) begin
    logic [1:0] a;
    logic [7:0] e;
    #2;
    if (!reset) begin
      sb.delete();
    end else begin
      chk("gnt_onehot", $onehot0(gnt), 1);
      chk("rsp_onehot", $onehot0(rsp_valid), 1);
      chk("gnt_rsp_excl", (|gnt) && (|rsp_valid), 0);
      if (|rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_rsp_valid", rsp_valid, e[7:4]);
          chk("sb_rsp_data", rsp_data, e[3:0]);
        end
      end
      if (|gnt) begin
        a = 2'b00;
        for (int i = 0; i < 4; i++) if (gnt[i]) a = req_addr[2*i +: 2];
        sb.push_back({gnt, a, ~a});
      end
    end
  end

  initial begin
    time last_t;
    vecs[0] = '{4'b1111, 8'b11_10_01_00, 4'b0001, 0};
    vecs[1] = '{4'b1110, 8'b11_10_01_00, 4'b0010, 4};
    vecs[2] = '{4'b1100, 8'b11_10_01_00, 4'b0100, 4};
    vecs[3] = '{4'b1000, 8'b11_10_01_00, 4'b1000, 4};
    vecs[4] = '{4'b0100, 8'b00_01_10_11, 4'b0100, 0};
    vecs[5] = '{4'b0101, 8'b00_01_10_11, 4'b0001, 0};
    vecs[6] = '{4'b0100, 8'b00_01_10_11, 4'b0100, 4};
    vecs[7] = '{4'b1001, 8'b01_00_11_10, 4'b1000, 0};
    vecs[8] = '{4'b0001, 8'b01_00_11_10, 4'b0001, 4};

    reset = 1'b0; req = '0; req_addr = '0; req3 = '0; req_addr3 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rom_en", rom_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rsp_data", rsp_data, 0);
    @(negedge clk);
    reset = 1'b1;

    // Single request: cycle-by-cycle timing.
    @(negedge clk);
    req = 4'b0001; req_addr = 8'b0000_0010;
    #1 chk("t1_gnt", gnt, 4'b0001);
    chk("t1_c0_en", rom_en, 0);
    @(negedge clk); req = '0;
    #1 chk("t1_c1_en", rom_en, 1);
    chk("t1_c1_addr", rom_addr, 2'b10);
    chk("t1_c1_busy", busy, 1);
    @(negedge clk);
    #1 chk("t1_c2_en", rom_en, 1);
    chk("t1_c2_addr", rom_addr, 2'b10);
    @(negedge clk);
    #1 chk("t1_c3_rsp", rsp_valid, 4'b0001);
    chk("t1_c3_data", rsp_data, 4'b1001);
    chk("t1_c3_en", rom_en, 0);
    @(negedge clk);
    #1 chk("t1_c4_busy", busy, 0);

    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Table: all-request ordering, spacing and pointer wrap.
    last_t = 0;
    for (int i = 0; i < 9; i++) begin
      wait_idle();
      req = vecs[i].req; req_addr = vecs[i].addr;
      #1 chk($sformatf("vec%0d_gnt", i), gnt, vecs[i].exp_gnt);
      if (vecs[i].gap != 0) chk($sformatf("vec%0d_gap", i), 32'(($time - last_t) / 10), vecs[i].gap);
      last_t = $time;
      @(negedge clk);
      req = req & ~vecs[i].exp_gnt;
    end
    req = '0;

    // Reset during WAIT aborts the transaction and restarts ptr at 0.
    wait_idle();
    req = 4'b0100; req_addr = 8'b00_11_00_00;
    #1 chk("t4_gnt", gnt, 4'b0100);
    @(negedge clk); req = '0;
    @(negedge clk);
    #1 reset = 1'b0;
    #1 chk("t4_busy", busy, 0);
    chk("t4_rom_en", rom_en, 0);
    chk("t4_rsp_valid", rsp_valid, 0);
    chk("t4_rom_addr", rom_addr, 0);
    chk("t4_rsp_data", rsp_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    req = 4'b1010; req_addr = 8'b10_00_01_00;
    #1 chk("t4_gnt_after", gnt, 4'b0010);
    @(negedge clk); req = '0;

    // Withdraw and change address after grant.
    wait_idle();
    req = 4'b0001; req_addr = 8'b0000_0010;
    #1 chk("t5_gnt", gnt, 4'b0001);
    @(negedge clk); req = '0; req_addr = '0;
    repeat (2) @(negedge clk);
    #1 chk("t5_rsp", rsp_valid, 4'b0001);
    chk("t5_data", rsp_data, 4'b1001);

    // A request dropped before it is arbitrated is never granted.
    wait_idle();
    req = 4'b0100; req_addr = 8'b0000_0000;
    #1 chk("t7_gnt", gnt, 4'b0100);
    @(negedge clk); req = 4'b1000;
    @(negedge clk); req = '0;
    wait_idle();
    #1 chk("t7_no_gnt", gnt, 0);
    @(negedge clk);
    #1 chk("t7_still_idle", busy, 0);

    // ROM_LAT=3 instance.
    @(negedge clk);
    req3 = 4'b0001; req_addr3 = 8'b0000_0001;
    #1 chk("t6_gnt", gnt3, 4'b0001);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); req3 = '0;
      #1 chk($sformatf("t6_c%0d_en", k), rom_en3, 1);
      chk($sformatf("t6_c%0d_rsp", k), rsp_valid3, 0);
    end
    @(negedge clk);
    #1 chk("t6_rsp", rsp_valid3, 4'b0001);
    chk("t6_data", rsp_data3, 4'b0110);
    chk("t6_en_off", rom_en3, 0);
    @(negedge clk);
    #1 chk("t6_idle", busy3, 0);

    repeat (3) @(negedge clk);
    #3 chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
